// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point SDF FFT datapath.
package fft_pkg;
   localparam int DATA_W = 24;
   localparam int FRAC_W = 8;

   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_BFLY = 2'd1;
   localparam logic [1:0] ST_TW   = 2'd2;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;
endpackage

// File: rtl/cmul_fx.sv
// Fixed-point complex multiply: full-width products, arithmetic shift by
// FRAC_W (floor), low DATA_W bits kept.
module cmul_fx
   import fft_pkg::*;
(
   input  cplx_t a,
   input  cplx_t w,
   output cplx_t p
);
   localparam int PW = 2 * DATA_W;

   logic signed [PW-1:0] rr;
   logic signed [PW-1:0] ii;
   logic signed [PW-1:0] ri;
   logic signed [PW-1:0] ir;
   logic signed [PW-1:0] pr;
   logic signed [PW-1:0] pi;

   always_comb begin
      rr = PW'(a.re) * PW'(w.re);
      ii = PW'(a.im) * PW'(w.im);
      ri = PW'(a.re) * PW'(w.im);
      ir = PW'(a.im) * PW'(w.re);
      pr = rr - ii;
      pi = ri + ir;
      p.re = DATA_W'(pr >>> FRAC_W);
      p.im = DATA_W'(pi >>> FRAC_W);
   end
endmodule

// File: rtl/sdf_r2_stage8.sv
// Radix-2 SDF DIF butterfly stage with a DELAY-deep feedback line and
// a drain counter that flushes the last twiddled half-frame.
module sdf_r2_stage8
   import fft_pkg::*;
#(
   parameter int DELAY = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] din_r,
   input  logic [DATA_W-1:0] din_i,
   input  logic [1:0]        state,
   input  logic [DATA_W-1:0] w_r,
   input  logic [DATA_W-1:0] w_i,
   output logic              out_valid,
   output logic [DATA_W-1:0] dout_r,
   output logic [DATA_W-1:0] dout_i
);
   localparam int CW = $clog2(DELAY + 1);

   cplx_t         dl_q [DELAY];
   cplx_t         dl_d [DELAY];
   cplx_t         dout_q;
   cplx_t         dout_d;
   cplx_t         x;
   cplx_t         h;
   cplx_t         w;
   cplx_t         tw;
   cplx_t         push;
   logic [CW-1:0] drain_cnt_q;
   logic [CW-1:0] drain_cnt_d;
   logic          out_valid_q;
   logic          out_valid_d;
   logic          iv_prev_q;
   logic          iv_prev_d;
   logic          last_bfly_q;
   logic          last_bfly_d;
   logic          adv;
   logic [1:0]    st;

   cmul_fx u_cmul (
      .a (h),
      .w (w),
      .p (tw)
   );

   always_comb begin
      st     = (state == 2'd3) ? ST_FILL : state;
      adv    = in_valid | (drain_cnt_q != '0);
      x.re   = in_valid ? din_r : '0;
      x.im   = in_valid ? din_i : '0;
      h      = dl_q[DELAY-1];
      w.re   = w_r;
      w.im   = w_i;
      dl_d        = dl_q;
      dout_d      = dout_q;
      out_valid_d = 1'b0;
      last_bfly_d = last_bfly_q;
      iv_prev_d   = in_valid;
      push        = x;
      if (adv) begin
         last_bfly_d = (st == ST_BFLY);
         unique case (st)
            ST_BFLY: begin
               dout_d.re   = h.re + x.re;
               dout_d.im   = h.im + x.im;
               push.re     = h.re - x.re;
               push.im     = h.im - x.im;
               out_valid_d = 1'b1;
            end
            ST_TW: begin
               dout_d      = tw;
               out_valid_d = 1'b1;
            end
            default: ;
         endcase
         dl_d[0] = push;
         for (int i = 1; i < DELAY; i++) begin
            dl_d[i] = dl_q[i-1];
         end
      end
      // a stream stop right after a butterfly run leaves DELAY differences to flush
      if (in_valid) begin
         drain_cnt_d = '0;
      end else if (iv_prev_q && last_bfly_q) begin
         drain_cnt_d = CW'(DELAY);
      end else if (adv) begin
         drain_cnt_d = drain_cnt_q - 1'b1;
      end else begin
         drain_cnt_d = drain_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DELAY; i++) begin
            dl_q[i] <= '0;
         end
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         drain_cnt_q <= '0;
         iv_prev_q   <= 1'b0;
         last_bfly_q <= 1'b0;
      end else begin
         dl_q        <= dl_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
         drain_cnt_q <= drain_cnt_d;
         iv_prev_q   <= iv_prev_d;
         last_bfly_q <= last_bfly_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout_r    = dout_q.re;
   assign dout_i    = dout_q.im;
endmodule

// File: tb/tb_sdf_r2_stage8.sv
// Self-checking bench for sdf_r2_stage8: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_sdf_r2_stage8;
   localparam int DW = 24;
   localparam int FW = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] din_r;
   logic [DW-1:0] din_i;
   logic [1:0]    state;
   logic [DW-1:0] w_r;
   logic [DW-1:0] w_i;
   logic          out_valid;
   logic [DW-1:0] dout_r;
   logic [DW-1:0] dout_i;

   sdf_r2_stage8 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .state     (state),
      .w_r       (w_r),
      .w_i       (w_i),
      .out_valid (out_valid),
      .dout_r    (dout_r),
      .dout_i    (dout_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int re;
      int im;
   } mc_t;

   typedef struct {
      bit iv;
      int st;
      int dr;
      int di;
      int wr;
      int wi;
      bit eov;
      int er;
      int ei;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   mc_t mq[$];
   int  m_drain;
   bit  m_prev_iv;
   bit  m_last_bfly;
   bit  m_ov;
   int  m_r;
   int  m_i;

   function automatic int w24(input longint v);
      logic [DW-1:0] t;
      t = v[DW-1:0];
      return int'($signed(t));
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < DEPTH; i++) mq.push_back('{re: 0, im: 0});
      m_drain     = 0;
      m_prev_iv   = 0;
      m_last_bfly = 0;
      m_ov        = 0;
      m_r         = 0;
      m_i         = 0;
   endtask

   task automatic model_tick(input bit iv, input int dr, input int di,
                             input int st, input int wr, input int wi);
      mc_t    h;
      mc_t    x;
      mc_t    p;
      longint pr;
      longint pi;
      bit     adv;
      int     s;
      adv  = iv || (m_drain != 0);
      s    = (st == 3) ? 0 : st;
      m_ov = 0;
      if (adv) begin
         h = mq[$];
         x = iv ? '{re: w24(dr), im: w24(di)} : '{re: 0, im: 0};
         p = x;
         if (s == 1) begin
            m_r  = w24(longint'(h.re) + x.re);
            m_i  = w24(longint'(h.im) + x.im);
            p    = '{re: w24(longint'(h.re) - x.re), im: w24(longint'(h.im) - x.im)};
            m_ov = 1;
         end else if (s == 2) begin
            pr   = longint'(h.re) * w24(wr) - longint'(h.im) * w24(wi);
            pi   = longint'(h.re) * w24(wi) + longint'(h.im) * w24(wr);
            m_r  = w24(pr >>> FW);
            m_i  = w24(pi >>> FW);
            m_ov = 1;
         end
         mq.push_front(p);
         void'(mq.pop_back());
      end
      if (iv) m_drain = 0;
      else if (m_prev_iv && m_last_bfly) m_drain = DEPTH;
      else if (adv) m_drain--;
      if (adv) m_last_bfly = (s == 1);
      m_prev_iv = iv;
   endtask

   task automatic step(input bit iv, input int dr, input int di,
                       input int st, input int wr, input int wi);
      in_valid = iv;
      din_r    = dr[DW-1:0];
      din_i    = di[DW-1:0];
      state    = st[1:0];
      w_r      = wr[DW-1:0];
      w_i      = wi[DW-1:0];
      @(posedge clk);
      #1;
      model_tick(iv, dr, di, st, wr, wi);
      chk("out_valid", longint'(out_valid), longint'(m_ov));
      chk("dout_r", longint'($signed(dout_r)), longint'(m_r));
      chk("dout_i", longint'($signed(dout_i)), longint'(m_i));
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      state    = 2'd0;
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_dout_r", longint'(dout_r), 0);
      chk("rst_dout_i", longint'(dout_i), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   vec_t tbl[$];
   int   xr[8] = '{4096, 100, 1, 32'h7FFFFF, 5, 7, 9, 11};
   int   xi[8] = '{0, 50, 0, 0, 6, 8, 10, 12};
   int   dr_[8] = '{2048, 0, 0, 1, 1, 2, 3, 4};
   int   di_[8] = '{0, 0, 0, 0, 1, 2, 3, 4};
   int   twr[8] = '{0, 181, 181, 256, 256, 256, 256, 256};
   int   twi[8] = '{-256, -181, -181, 0, 0, 0, 0, 0};
   int   pulses;

   initial begin
      for (int n = 0; n < 8; n++)
         tbl.push_back('{1, 0, 256 * n, 0, 0, 0, 0, 0, 0});
      for (int n = 0; n < 8; n++)
         tbl.push_back('{1, 1, 256 * (n + 8), 0, 0, 0, 1, 256 * (2 * n + 8), 0});
      for (int n = 0; n < 8; n++)
         tbl.push_back('{1, 2, 256 * (n + 16), 0, 256, 0, 1, -2048, 0});

      reset = 1'b1;
      in_valid = 1'b0;
      din_r = '0;
      din_i = '0;
      state = '0;
      w_r = '0;
      w_i = '0;
      @(posedge clk);
      #1;
      do_reset();

      // fill, butterfly sums, W = 1 twiddle run
      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].iv, tbl[k].dr, tbl[k].di, tbl[k].st, tbl[k].wr, tbl[k].wi);
         chk("tbl_valid", longint'(out_valid), longint'(tbl[k].eov));
         chk("tbl_re", longint'($signed(dout_r)), longint'(tbl[k].er));
         chk("tbl_im", longint'($signed(dout_i)), longint'(tbl[k].ei));
      end

      // reset with a loaded delay line and dout = -2048
      do_reset();
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         step(1, 300 + k, -k, 0, 0, 0);
         pulses += int'(out_valid);
      end
      chk("fill_after_reset_pulses", pulses, 0);
      for (int k = 0; k < 8; k++) step(1, 0, 0, 1, 0, 0);

      // W = -j, rounding, truncation, wrap, then drain
      do_reset();
      for (int k = 0; k < 8; k++) step(1, xr[k], xi[k], 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         step(1, dr_[k], di_[k], 1, 0, 0);
         if (k == 3) chk("wrap_r", longint'(dout_r), 'h800000);
      end
      step(0, 0, 0, 2, twr[0], twi[0]);
      chk("fall_quiet", longint'(out_valid), 0);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 0, 2, twr[k], twi[k]);
         pulses += int'(out_valid);
         if (k == 0) begin
            chk("tw_mj_re", longint'($signed(dout_r)), 0);
            chk("tw_mj_im", longint'($signed(dout_i)), -2048);
         end else if (k == 1) begin
            chk("tw_45_re", longint'($signed(dout_r)), 106);
            chk("tw_45_im", longint'($signed(dout_i)), -36);
         end else if (k == 2) begin
            chk("trunc_re", longint'($signed(dout_r)), 0);
            chk("trunc_im", longint'($signed(dout_i)), -1);
         end else if (k == 3) begin
            chk("drain_wrap_diff", longint'(dout_r), 'h7FFFFE);
         end
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0, 0);
         pulses += int'(out_valid);
      end
      chk("drain_pulses", pulses, 8);

      // gaps: 1 cycle inside a butterfly run, 3 cycles inside a twiddle run
      do_reset();
      for (int k = 0; k < 8; k++)
         step(1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 0, 0, 0);
      pulses = 0;
      for (int k = 0; k < 9; k++) begin
         step(k != 3, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1, 0, 0);
         pulses += int'(out_valid);
      end
      chk("gap_bfly_pulses", pulses, 8);
      pulses = 0;
      for (int k = 0; k < 11; k++) begin
         step(!(k >= 4 && k <= 6), int'($urandom_range(0, 999)), int'($urandom_range(0, 999)), 2,
              int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
         pulses += int'(out_valid);
      end
      chk("gap_tw_pulses", pulses, 8);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 2, 256, 0);
         pulses += int'(out_valid);
      end
      chk("no_drain_after_tw", pulses, 0);

      // randomized traffic
      do_reset();
      for (int k = 0; k < 800; k++) begin
         step($urandom_range(0, 3) != 0, int'($urandom), int'($urandom),
              int'($urandom_range(0, 3)), int'($urandom), int'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
